// File: rtl/kan_pe_scheduler_if.sv
// Requester, shared-PE and response-path signals of kan_pe_scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface kan_pe_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic                          enable;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         pe_x;
  logic                          pe_x_valid;
  logic                          pe_x_ready;
  logic [4:0]                    pe_spline_select;
  logic [DATA_WIDTH-1:0]         pe_y;
  logic                          pe_y_valid;
  logic                          pe_y_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic                          busy;
  logic                          err_orphan;

  modport master (
    output enable, req_data, req_valid, pe_x_ready, pe_y, pe_y_valid, rsp_ready,
    input  req_ready, pe_x, pe_x_valid, pe_spline_select, pe_y_ready,
           rsp_data, rsp_valid, busy, err_orphan
  );

  modport slave (
    input  enable, req_data, req_valid, pe_x_ready, pe_y, pe_y_valid, rsp_ready,
    output req_ready, pe_x, pe_x_valid, pe_spline_select, pe_y_ready,
           rsp_data, rsp_valid, busy, err_orphan
  );
endinterface

// File: rtl/kan_pe_scheduler.sv
// Round-robin scheduler sharing one in-order KAN PE among NUM_REQ requesters.
// Tags of in-flight samples ride a FIFO so each result returns to its requester.
module kan_pe_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TAG_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  kan_pe_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int FP_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W = FP_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q;
  logic                  live_q;
  logic [PTR_W-1:0]      ptr_q;
  logic                  iss_vld_q;
  logic [DATA_WIDTH-1:0] iss_data_q;
  logic [PTR_W-1:0]      iss_tag_q;
  logic [PTR_W-1:0]      fifo_mem_q [TAG_DEPTH];
  logic [FP_W-1:0]       wr_ptr_q;
  logic [FP_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]    rsp_oh_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] req_word_s [NUM_REQ];
  logic [PTR_W:0]        sum_s;
  logic [PTR_W-1:0]      grant_s;
  logic                  grant_vld_s;
  logic [PTR_W-1:0]      ptr_d;
  logic [CNT_W-1:0]      outstanding_s;
  logic [CNT_W-1:0]      cnt_d;
  logic                  pe_x_hs_s;
  logic                  slot_ok_s;
  logic                  accept_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic                  rsp_hs_s;
  logic                  pe_y_ready_s;
  logic                  pe_y_hs_s;
  logic                  pop_s;
  logic                  orphan_s;
  logic                  iss_vld_d;
  logic                  rsp_vld_d;
  logic                  idle_ok_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_word
    assign req_word_s[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    sum_s       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!grant_vld_s && bus.req_valid[sum_s[PTR_W-1:0]]) begin
        grant_s     = sum_s[PTR_W-1:0];
        grant_vld_s = 1'b1;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Handshake qualification and next-state occupancy of the three storage stages
  always_comb begin
    pe_x_hs_s     = iss_vld_q & bus.pe_x_ready;
    outstanding_s = cnt_q + CNT_W'(iss_vld_q);
    slot_ok_s     = (state_q == ST_RUN) && (!iss_vld_q || pe_x_hs_s) &&
                    (outstanding_s < CNT_W'(TAG_DEPTH));
    accept_s      = slot_ok_s && grant_vld_s;
    if (accept_s) begin
      req_ready_s = onehot(grant_s);
    end else begin
      req_ready_s = '0;
    end
    if (grant_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_s + PTR_W'(1);
    end
    rsp_hs_s     = |(rsp_oh_q & bus.rsp_ready);
    pe_y_ready_s = live_q && ((rsp_oh_q == '0) || rsp_hs_s);
    pe_y_hs_s    = bus.pe_y_valid && pe_y_ready_s;
    pop_s        = pe_y_hs_s && (cnt_q != '0);
    orphan_s     = pe_y_hs_s && (cnt_q == '0);
    case ({pe_x_hs_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    iss_vld_d = accept_s || (iss_vld_q && !pe_x_hs_s);
    rsp_vld_d = pop_s || ((rsp_oh_q != '0) && !rsp_hs_s);
    // Looking at next-state occupancy lets busy fall right after the last rsp handshake
    idle_ok_s = !iss_vld_d && (cnt_d == '0) && !rsp_vld_d;
  end

  // Mode FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_q <= bus.enable ? ST_RUN : ST_IDLE;
        ST_RUN:   state_q <= bus.enable ? ST_RUN : ST_DRAIN;
        ST_DRAIN: begin
          if (bus.enable) begin
            state_q <= ST_RUN;
          end else if (idle_ok_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Issue register, tag FIFO pointers, response register and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      ptr_q      <= '0;
      iss_vld_q  <= 1'b0;
      iss_data_q <= '0;
      iss_tag_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rsp_oh_q   <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      iss_vld_q <= iss_vld_d;
      cnt_q     <= cnt_d;
      if (accept_s) begin
        iss_data_q <= req_word_s[grant_s];
        iss_tag_q  <= grant_s;
        ptr_q      <= ptr_d;
      end
      if (pe_x_hs_s) begin
        wr_ptr_q <= wr_ptr_q + FP_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q   <= rd_ptr_q + FP_W'(1);
        rsp_oh_q   <= onehot(fifo_mem_q[rd_ptr_q]);
        rsp_data_q <= bus.pe_y;
      end else if (rsp_hs_s) begin
        rsp_oh_q <= '0;
      end
      if (orphan_s) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage; validity is tracked by the pointers and count above
  always_ff @(posedge clk) begin
    if (pe_x_hs_s) begin
      fifo_mem_q[wr_ptr_q] <= iss_tag_q;
    end
  end

  assign bus.req_ready        = req_ready_s;
  assign bus.pe_x             = iss_data_q;
  assign bus.pe_x_valid       = iss_vld_q;
  assign bus.pe_spline_select = 5'(iss_tag_q);
  assign bus.pe_y_ready       = pe_y_ready_s;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_valid        = rsp_oh_q;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.err_orphan       = err_q;
endmodule

// File: tb/tb_kan_pe_scheduler.sv
// Directed bench for kan_pe_scheduler (DATA_WIDTH=32, NUM_REQ=4, TAG_DEPTH=16).
module tb_kan_pe_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   accepts = 0;
  logic [3:0] oh;

  kan_pe_scheduler_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus ();

  kan_pe_scheduler #(.DATA_WIDTH(32), .NUM_REQ(4), .TAG_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh4(input int i);
    logic [3:0] v;
    v = 4'b0000;
    v[i % 4] = 1'b1;
    return v;
  endfunction

  initial begin
    bus.enable = 1'b0; bus.req_data = '0; bus.req_valid = 4'b0000;
    bus.pe_x_ready = 1'b0; bus.pe_y = 32'h0; bus.pe_y_valid = 1'b0; bus.rsp_ready = 4'b0000;

    // Reset values
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_pe_x_valid", 64'(bus.pe_x_valid), 64'h0);
    chk("rst_pe_y_ready", 64'(bus.pe_y_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_busy_err", 64'({bus.busy, bus.err_orphan}), 64'h0);

    // Single request
    tick();
    rst_n = 1'b1; bus.enable = 1'b1; bus.req_valid = 4'b0001;
    bus.req_data[31:0] = 32'h0000_1234; bus.pe_x_ready = 1'b1;
    #1;
    chk("idle_no_ready", 64'(bus.req_ready), 64'h0);
    chk("idle_pe_y_ready", 64'(bus.pe_y_ready), 64'h0);
    tick();
    chk("run_busy", 64'(bus.busy), 64'h1);
    chk("run_ready0", 64'(bus.req_ready), 64'h1);
    chk("run_no_issue", 64'(bus.pe_x_valid), 64'h0);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_pe_x_valid", 64'(bus.pe_x_valid), 64'h1);
    chk("single_pe_x", 64'(bus.pe_x), 64'h1234);
    chk("single_sel", 64'(bus.pe_spline_select), 64'h0);
    tick();
    chk("single_issue_done", 64'(bus.pe_x_valid), 64'h0);
    bus.pe_y = 32'h0000_ABCD; bus.pe_y_valid = 1'b1;
    #1;
    chk("single_pe_y_ready", 64'(bus.pe_y_ready), 64'h1);
    tick();
    bus.pe_y_valid = 1'b0;
    chk("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("single_rsp_data", 64'(bus.rsp_data), 64'hABCD);
    tick();
    chk("rsp_hold", 64'(bus.rsp_valid), 64'h1);
    bus.rsp_ready = 4'b1110;
    #1;
    chk("rsp_other_ready_ignored", 64'(bus.pe_y_ready), 64'h0);
    tick();
    chk("rsp_still_held", 64'(bus.rsp_valid), 64'h1);
    bus.rsp_ready = 4'b0001;
    #1;
    chk("rsp_drain_pe_y_ready", 64'(bus.pe_y_ready), 64'h1);
    tick();
    chk("rsp_released", 64'(bus.rsp_valid), 64'h0);
    bus.rsp_ready = 4'b1111;

    // Fairness and back-pressure to full: ptr is 1 after the single request
    for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), (k < 16) ? 64'(oh4(1 + k)) : 64'h0);
      if (k >= 1 && k <= 16) begin
        chk($sformatf("rr_sel_%0d", k), 64'(bus.pe_spline_select), 64'(k % 4));
        chk($sformatf("rr_pe_x_%0d", k), 64'(bus.pe_x), 64'(32'hA000_0000 + 32'(k % 4)));
      end
      if (bus.req_ready != 4'b0000) accepts++;
      tick();
    end
    chk("full_accepts", 64'(accepts), 64'd16);
    chk("full_no_ready", 64'(bus.req_ready), 64'h0);
    chk("full_no_issue", 64'(bus.pe_x_valid), 64'h0);

    // Return 16 results in issue order
    bus.req_valid = 4'b0000; bus.pe_y_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      bus.pe_y = 32'h100 + 32'(j);
      #1;
      chk($sformatf("ret_pe_y_ready_%0d", j), 64'(bus.pe_y_ready), 64'h1);
      tick();
      chk($sformatf("ret_tag_%0d", j), 64'(bus.rsp_valid), 64'(oh4(1 + j)));
      chk($sformatf("ret_data_%0d", j), 64'(bus.rsp_data), 64'(32'h100 + 32'(j)));
    end
    bus.pe_y_valid = 1'b0;
    tick();
    chk("ret_empty", 64'(bus.rsp_valid), 64'h0);

    // Response stall with three results from requester 2
    bus.req_valid = 4'b0100; bus.rsp_ready = 4'b0000;
    tick(); tick(); tick();
    bus.req_valid = 4'b0000;
    tick();
    bus.pe_y = 32'h201; bus.pe_y_valid = 1'b1;
    #1;
    chk("stall_first_ready", 64'(bus.pe_y_ready), 64'h1);
    tick();
    chk("stall_rsp1", 64'({bus.rsp_valid, bus.rsp_data}), {28'h0, 4'b0100, 32'h201});
    bus.pe_y = 32'h202;
    #1;
    chk("stall_blocked", 64'(bus.pe_y_ready), 64'h0);
    tick();
    chk("stall_rsp1_kept", 64'(bus.rsp_data), 64'h201);
    bus.rsp_ready = 4'b1111;
    tick();
    chk("stall_rsp2", 64'({bus.rsp_valid, bus.rsp_data}), {28'h0, 4'b0100, 32'h202});
    bus.pe_y = 32'h203;
    tick();
    chk("stall_rsp3", 64'({bus.rsp_valid, bus.rsp_data}), {28'h0, 4'b0100, 32'h203});
    bus.pe_y_valid = 1'b0;
    tick();
    chk("stall_done", 64'(bus.rsp_valid), 64'h0);

    // Drain: five outstanding from requester 1, then enable drops
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    bus.enable = 1'b0; bus.req_valid = 4'b0000;
    tick();
    bus.req_valid = 4'b0010;
    #1;
    chk("drain_no_ready", 64'(bus.req_ready), 64'h0);
    chk("drain_busy", 64'(bus.busy), 64'h1);
    bus.pe_y_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      bus.pe_y = 32'h300 + 32'(j);
      tick();
      chk($sformatf("drain_data_%0d", j), 64'(bus.rsp_data), 64'(32'h300 + 32'(j)));
      chk($sformatf("drain_busy_%0d", j), 64'({bus.busy, bus.req_ready}), 64'h10);
    end
    bus.pe_y_valid = 1'b0;
    tick();
    chk("drain_idle", 64'({bus.busy, bus.rsp_valid}), 64'h0);
    bus.req_valid = 4'b0000;

    // Orphan result
    #1;
    chk("orphan_pe_y_ready", 64'(bus.pe_y_ready), 64'h1);
    bus.pe_y = 32'hDEAD; bus.pe_y_valid = 1'b1;
    tick();
    bus.pe_y_valid = 1'b0;
    chk("orphan_flag", 64'(bus.err_orphan), 64'h1);
    chk("orphan_no_rsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    chk("orphan_sticky", 64'(bus.err_orphan), 64'h1);

    // Reset mid-stream with a sample stuck in the issue register
    bus.enable = 1'b1; bus.req_valid = 4'b1111; bus.pe_x_ready = 1'b0;
    tick(); tick();
    chk("pre_rst_sel", 64'({bus.pe_x_valid, bus.pe_spline_select}), {58'h0, 1'b1, 5'd2});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready_valid", 64'({bus.req_ready, bus.pe_x_valid, bus.pe_y_ready}), 64'h0);
    chk("arst_pe_x_sel", 64'({bus.pe_x, bus.pe_spline_select}), 64'h0);
    chk("arst_rsp", 64'({bus.rsp_valid, bus.rsp_data}), 64'h0);
    chk("arst_busy_err", 64'({bus.busy, bus.err_orphan}), 64'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 64'({bus.req_ready, bus.busy}), 64'h0);
    tick();
    chk("post_rst_ready", 64'({bus.req_ready, bus.pe_x_valid}), {59'h0, 4'b0001, 1'b0});
    bus.pe_x_ready = 1'b1;
    tick();
    chk("post_rst_issue", 64'({bus.pe_x_valid, bus.pe_spline_select}), {58'h0, 1'b1, 5'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kan_pe_scheduler.md
KAN_PE_SCHEDULER -- requirements
Module: kan_pe_scheduler

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, sample/result width.
- NUM_REQ, 4, number of requesters (2..16).
- TAG_DEPTH, 16, maximum in-flight samples (power of 2).
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  high permits new issues.
REQ-005 req_data  input  NUM_REQ*DATA_WIDTH  requester samples; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 req_valid / req_ready  input / output  NUM_REQ each  per-requester handshake.
REQ-007 pe_x / pe_x_valid / pe_x_ready  output / output / input  DATA_WIDTH / 1 / 1  sample to the shared PE.
REQ-008 pe_spline_select  output  5  coefficient bank for pe_x; equals the zero-extended requester index.
REQ-009 pe_y / pe_y_valid / pe_y_ready  input / input / output  DATA_WIDTH / 1 / 1  PE result.
REQ-010 rsp_data / rsp_valid / rsp_ready  output / output / input  DATA_WIDTH / NUM_REQ (one-hot) / NUM_REQ  result return path.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 err_orphan  output  1  sticky flag: result arrived with no tag.

Function
REQ-013 States SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN: enable=1.
- RUN->DRAIN: enable=0.
- DRAIN->RUN: enable=1.
- DRAIN->IDLE: issue register empty, tag FIFO empty and response register empty.
REQ-014 Arbitration SHALL be round-robin with a pointer ptr, reset 0.
- The grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
- After an accepted request from i, ptr becomes (i+1) mod NUM_REQ.
- ptr holds when no request is accepted.
REQ-015 req_ready[i] SHALL be 1 only when all of the following hold:
- state==RUN;
- i is the granted requester;
- the issue register is empty or pe_x is handshaking this cycle;
- outstanding < TAG_DEPTH.
At most one req_ready bit is high per cycle.
REQ-016 Issue register timing:
- A request accepted in cycle N loads the issue register (data, tag=i).
- pe_x_valid=1 from cycle N+1 and holds, with pe_x and pe_spline_select stable, until pe_x_ready=1.
REQ-017 On a pe_x handshake, the tag SHALL be pushed into the tag FIFO (depth TAG_DEPTH).
REQ-018 outstanding SHALL count issue-register occupancy plus tag FIFO count. It never exceeds TAG_DEPTH; simultaneous accept and return leave it unchanged.
REQ-019 pe_y_ready SHALL be high when the response register is empty or is draining this cycle (rsp handshake).
REQ-020 On a pe_y handshake, the response register SHALL load pe_y together with the tag popped from the FIFO. From the next cycle it drives rsp_data=pe_y and rsp_valid=one-hot(tag).
REQ-021 rsp_valid SHALL hold until rsp_ready[tag]=1. rsp_ready bits of other requesters are ignored.
REQ-022 Results SHALL be returned in issue order; the PE is in-order.
REQ-023 Orphan results: a pe_y handshake with an empty tag FIFO sets err_orphan, and the result is dropped (response register unchanged). err_orphan clears only on reset.
REQ-024 Simultaneous FIFO push and pop SHALL be legal at any occupancy, including full and empty, with count unchanged. A push in the same cycle as a pop from empty returns the new tag no earlier than the next pop.
REQ-025 enable deasserted mid-stream:
- No new accepts.
- The issue register still completes its pe_x handshake.
- All outstanding results still return.
REQ-026 Pointer, FIFO read/write pointers and outstanding count SHALL wrap modulo their range with no lost or duplicated entries.

Reset
REQ-027 While rst_n=0, asynchronously and independent of clk, the block SHALL hold:
- state=IDLE, ptr=0, FIFO empty, outstanding=0;
- issue and response registers empty;
- req_ready=0, pe_x_valid=0, pe_x=0, pe_spline_select=0;
- pe_y_ready=0, rsp_valid=0, rsp_data=0, busy=0, err_orphan=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight tags and results. The first accept after release occurs no earlier than the second rising edge with enable=1.

Verification
REQ-029 Single request: enable=1, req_valid=0001, req_data[0]=0x00001234, pe_x_ready=1, PE returns 0x0000ABCD four cycles later -> pe_x=0x00001234 with pe_spline_select=0; then rsp_valid=0001, rsp_data=0x0000ABCD.
REQ-030 Fairness: req_valid=1111 held, pe_x_ready=1 -> grant order 0,1,2,3,0,1,... with no requester skipped or granted twice in a row.
REQ-031 Back-pressure to full: pe_y_valid=0 for 40 cycles -> exactly 16 samples issued, req_ready=0 afterwards, outstanding=16; returning 16 results yields rsp tags in issue order.
REQ-032 Response stall: rsp_ready=0000 with 3 results pending -> pe_y_ready=0 after the first result; raising rsp_ready to 1111 delivers all three in order with none lost.
REQ-033 Drain: 5 outstanding, enable drops -> no further req_ready; busy stays 1 until the 5th rsp handshake, then state=IDLE and busy=0 on the next cycle.
REQ-034 Orphan and reset: pe_y_valid=1 with empty FIFO -> err_orphan=1, no rsp_valid; rst_n=0 mid-stream -> all outputs at reset values immediately, err_orphan=0.
